// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-addressed, single-lane-select data memory.
// Optional STORE_READBACK_EN adds a VERIFY state that reads back stored lanes.
module mem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [31:0]       mem_Din,
    output logic              mem_MemWrite,
    output logic [3:0]        mem_sel,
    input  logic [31:0]       mem_Dout
);

`ifdef STORE_READBACK_EN
    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD, VERIFY} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD} state_t;
`endif

    state_t      state, state_d;
    logic        done_d, fault_d;
    logic [2:0]  op_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic        illegal, misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    function automatic logic [3:0] lane(input logic [1:0] idx);
        lane = 4'b0001 << idx;
    endfunction

    assign illegal    = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[2]);
    assign misaligned = ((op[1:0] == 2'b01) && addr[0]) || ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign busy       = (state != IDLE);

    always_comb begin
        ld_byte = mem_Dout[7:0];
        case (addr_q)
            2'd1:    ld_byte = mem_Dout[15:8];
            2'd2:    ld_byte = mem_Dout[23:16];
            2'd3:    ld_byte = mem_Dout[31:24];
            default: ld_byte = mem_Dout[7:0];
        endcase
        ld_half = addr_q[1] ? mem_Dout[31:16] : mem_Dout[15:0];
        case (op_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = mem_Dout;
        endcase
    end

`ifdef STORE_READBACK_EN
    // Lanes touched by the store and the data each lane should now hold.
    logic [3:0]  vmask;
    logic [31:0] vexp, vmask32;

    always_comb begin
        vmask   = 4'b1111;
        vexp    = wdata_q;
        vmask32 = '0;
        case (op_q[1:0])
            2'b00: begin
                vmask = lane(addr_q);
                vexp  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                vmask = addr_q[1] ? 4'b1100 : 4'b0011;
                vexp  = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) vmask32[8*i +: 8] = {8{vmask[i]}};
    end
`endif

    always_comb begin
        state_d      = state;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        mem_MemWrite = 1'b0;
        mem_sel      = 4'b0000;
        mem_Din      = 32'd0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal || misaligned) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = we ? WR_LO : RD;
                    end
                end
            end
            WR_LO: begin
                mem_MemWrite = 1'b1;
                mem_Din      = {4{wdata_q[7:0]}};
                case (op_q[1:0])
                    2'b10: begin
                        mem_sel = 4'b1111;
                        mem_Din = wdata_q;
                    end
                    2'b01:   mem_sel = lane({addr_q[1], 1'b0});
                    default: mem_sel = lane(addr_q);
                endcase
                if (op_q[1:0] == 2'b01) begin
                    state_d = WR_HI;
                end else begin
`ifdef STORE_READBACK_EN
                    state_d = VERIFY;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
            WR_HI: begin
                mem_MemWrite = 1'b1;
                mem_sel      = lane({addr_q[1], 1'b1});
                mem_Din      = {4{wdata_q[15:8]}};
`ifdef STORE_READBACK_EN
                state_d = VERIFY;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
            RD: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`ifdef STORE_READBACK_EN
            VERIFY: begin
                state_d = IDLE;
                done_d  = 1'b1;
                fault_d = |((mem_Dout ^ vexp) & vmask32);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // mem_Addr only moves for accepted, non-faulting requests so it holds between accesses.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            fault    <= 1'b0;
            rdata    <= 32'd0;
            mem_Addr <= '0;
            op_q     <= 3'd0;
            addr_q   <= 2'd0;
            wdata_q  <= 32'd0;
        end else begin
            state <= state_d;
            done  <= done_d;
            fault <= fault_d;
            if (state == IDLE && req) begin
                op_q    <= op;
                addr_q  <= addr[1:0];
                wdata_q <= wdata;
                if (!(illegal || misaligned)) mem_Addr <= addr[ADDR_W+1:2];
            end
            if (state == RD) rdata <= load_val;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-level reference memory model,
// directed scenarios followed by randomized back-to-back accesses.
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        rst_n, req, we;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        busy, done, fault, mem_MemWrite;
    logic [31:0] rdata, mem_Din, mem_Dout;
    logic [9:0]  mem_Addr;
    logic [3:0]  mem_sel;

    logic [31:0] mem [0:1023];
    logic [7:0]  refMem [0:4095];
    logic [31:0] modelRdata;
    bit          loadMem;
    int          checks = 0;
    int          errors = 0;

`ifdef STORE_READBACK_EN
    localparam int VERIFY_EXTRA = 1;
`else
    localparam int VERIFY_EXTRA = 0;
`endif

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.ADDR_W(10)) dut (
        .CLK(CLK), .rst_n(rst_n), .req(req), .we(we), .op(op), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_Addr(mem_Addr), .mem_Din(mem_Din), .mem_MemWrite(mem_MemWrite),
        .mem_sel(mem_sel), .mem_Dout(mem_Dout)
    );

    // Data memory: combinational read, lane-masked write at the clock edge.
    assign mem_Dout = mem[mem_Addr];

    always @(posedge CLK) begin
        if (loadMem) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= {refMem[4*i+3], refMem[4*i+2], refMem[4*i+1], refMem[4*i]};
        end else if (mem_MemWrite) begin
            for (int l = 0; l < 4; l++)
                if (mem_sel[l]) mem[mem_Addr][8*l +: 8] <= mem_Din[8*l +: 8];
        end
    end

    function automatic logic [31:0] refWord(input int w);
        refWord = {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request (starting at a negedge) and checks it up to and including its done cycle.
    task automatic applyStimulus(input logic w, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] d, input bit keepReq);
        int          size, ba, expLat, nExpWr, nWr, lat;
        bit          isSigned, expFault, gotDone;
        longint      val;
        int          expLane [2];
        logic [7:0]  expByte [2];
        logic [3:0]  gotSel [4];
        logic [31:0] gotDin [4];
        logic [9:0]  gotAddr [4];

        ba = int'(a[11:0]);
        isSigned = 1'b0;
        case (o)
            3'b000: begin size = 1; isSigned = 1'b1; end
            3'b001: begin size = 2; isSigned = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        if (size == 0) expFault = 1'b1;
        else expFault = (w && o[2]) || (ba % size != 0);

        nExpWr = 0;
        expLane[0] = 0; expLane[1] = 0;
        expByte[0] = 8'h00; expByte[1] = 8'h00;
        if (expFault) begin
            expLat = 1;
        end else if (w) begin
            nExpWr = (size == 2) ? 2 : 1;
            expLat = ((size == 2) ? 3 : 2) + VERIFY_EXTRA;
            for (int b = 0; b < size; b++) refMem[ba+b] = d[8*b +: 8];
            for (int i = 0; i < nExpWr; i++) begin
                expLane[i] = (ba % 4) + i;
                expByte[i] = d[8*i +: 8];
            end
        end else begin
            expLat = 2;
            val = 0;
            for (int b = 0; b < size; b++) val += longint'(refMem[ba+b]) << (8*b);
            if (isSigned && val >= (longint'(1) << (8*size-1))) val -= (longint'(1) << (8*size));
            modelRdata = 32'(val);
        end

        we = w; op = o; addr = a; wdata = d; req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        if (!keepReq) req = 1'b0;

        nWr = 0; lat = 0; gotDone = 1'b0;
        for (int k = 1; k <= 12 && !gotDone; k++) begin
            if (k > 1) @(negedge CLK);
            lat = k;
            if (mem_MemWrite === 1'b1) begin
                if (nWr < 4) begin
                    gotSel[nWr]  = mem_sel;
                    gotDin[nWr]  = mem_Din;
                    gotAddr[nWr] = mem_Addr;
                end
                nWr++;
            end
            if (done === 1'b1) gotDone = 1'b1;
        end

        checkOutput("done_seen", 32'(gotDone), 32'd1);
        if (gotDone) begin
            checkOutput("latency", lat, expLat);
            checkOutput("fault", 32'(fault), 32'(expFault));
            checkOutput("busy_at_done", 32'(busy), 32'd0);
            checkOutput("idle_outputs", {mem_Din[27:0], mem_sel}, 32'd0);
            checkOutput("idle_memwrite", 32'(mem_MemWrite), 32'd0);
        end
        checkOutput("write_count", nWr, nExpWr);
        for (int i = 0; i < nExpWr && i < nWr && i < 4; i++) begin
            checkOutput("wr_addr", 32'(gotAddr[i]), 32'(a[11:2]));
            if (size == 4) begin
                checkOutput("wr_sel_w", 32'(gotSel[i]), 32'hF);
                checkOutput("wr_din_w", gotDin[i], d);
            end else begin
                checkOutput("wr_sel", 32'(gotSel[i]), 32'(1) << expLane[i]);
                checkOutput("wr_lane_data", (gotDin[i] >> (8*expLane[i])) & 32'hFF, 32'(expByte[i]));
            end
        end
        checkOutput("rdata", rdata, modelRdata);
        if (!expFault && w) checkOutput("mem_word", mem[ba/4], refWord(ba/4));
    endtask

    initial begin
        logic        rw;
        logic [2:0]  ro;
        logic [31:0] ra;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
        modelRdata = 32'd0;
        for (int i = 0; i < 4096; i++) refMem[i] = 8'($urandom);
        loadMem = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        loadMem = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_fault", 32'(fault), 32'd0);
        checkOutput("reset_memwrite", 32'(mem_MemWrite), 32'd0);
        checkOutput("reset_sel", 32'(mem_sel), 32'd0);
        checkOutput("reset_din", mem_Din, 32'd0);
        checkOutput("reset_addr", 32'(mem_Addr), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        // Word store then load back
        applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
        checkOutput("t1_lw", rdata, 32'hDEADBEEF);

        // Halfword store split across two lanes
        applyStimulus(1'b1, 3'b010, 32'h4, 32'h11223344, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h6, 32'h0000A55A, 1'b0);
        checkOutput("t2_word1", mem[1], 32'hA55A3344);

        applyStimulus(1'b0, 3'b000, 32'h7, 32'h0, 1'b0);
        checkOutput("t3_lb", rdata, 32'hFFFFFFA5);
        applyStimulus(1'b0, 3'b100, 32'h7, 32'h0, 1'b0);
        checkOutput("t3_lbu", rdata, 32'h000000A5);
        applyStimulus(1'b0, 3'b001, 32'h6, 32'h0, 1'b0);
        checkOutput("t3_lh", rdata, 32'hFFFFA55A);
        applyStimulus(1'b0, 3'b101, 32'h4, 32'h0, 1'b0);
        checkOutput("t3_lhu", rdata, 32'h00003344);

        // Faulting requests leave memory and rdata alone
        applyStimulus(1'b1, 3'b010, 32'h2, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h3, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 3'b100, 32'h0, 32'h99, 1'b0);
        checkOutput("t4_rdata_kept", rdata, 32'h00003344);

        // Asynchronous reset in the middle of the second halfword write
        applyStimulus(1'b1, 3'b010, 32'h4, 32'h11223344, 1'b0);
        we = 1'b1; op = 3'b001; addr = 32'h6; wdata = 32'h0000A55A; req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        checkOutput("t5_wrlo_sel", 32'(mem_sel), 32'h4);
        @(negedge CLK);
        checkOutput("t5_wrhi_sel", 32'(mem_sel), 32'h8);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_memwrite", 32'(mem_MemWrite), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_sel", 32'(mem_sel), 32'd0);
        checkOutput("t5_rst_rdata", rdata, 32'd0);
        refMem[6] = 8'h5A;
        modelRdata = 32'd0;
        @(negedge CLK);
        rst_n = 1'b1;
        checkOutput("t5_word1", mem[1], 32'h115A3344);
        applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 1'b0);

        // Held req during a halfword store, then a byte store accepted on the done cycle
        applyStimulus(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 1'b1);
        applyStimulus(1'b1, 3'b000, 32'h9, 32'h00000077, 1'b0);

        // Randomized traffic over a small window so stores and loads collide
        for (int n = 0; n < 200; n++) begin
            rw = 1'($urandom);
            ro = 3'($urandom);
            ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
            applyStimulus(rw, ro, ra, $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store initiator that drives the data memory's word-addressed, single-byte-lane write port on behalf of the CPU's MEM stage. It converts RISC-V byte addresses and funct3 sizes (lb/lh/lw/lbu/lhu/sb/sh/sw) into memory transactions. Halfword stores take two single-lane writes, because the memory accepts only sel = 1111, 0001, 0010, 0100 or 1000. It also extracts and sign/zero-extends load data and flags misaligned or illegal requests.

Parameters:
ADDR_W, 10, width of the word address driven to memory; mem_Addr = addr[ADDR_W+1:2], upper bits ignored.

Ports:
CLK  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req  in  1  request strobe, sampled only when busy=0
we  in  1  1 = store, 0 = load
op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address
wdata  in  32  store data, right-aligned
busy  out  1  high while an access is in flight
done  out  1  one-cycle completion pulse
fault  out  1  valid with done; misaligned or illegal op
rdata  out  32  extended load result; held until the next load completes
mem_Addr  out  ADDR_W  word address to memory
mem_Din  out  32  write data, lane-positioned
mem_MemWrite  out  1  memory write enable
mem_sel  out  4  byte-lane select
mem_Dout  in  32  combinational memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, fault, mem_MemWrite = 0. mem_sel = 0, mem_Din = 0, mem_Addr = 0, rdata = 0. Outputs drop immediately, not at the next edge.
- States: IDLE, WR_LO, WR_HI, RD. busy = (state != IDLE).
- IDLE, req=1 at edge T:
  - Latch we/op/addr/wdata.
  - Fault check: illegal op is any of 011/110/111, or a store with op 100/101. Misaligned is H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Fault: stay IDLE; cycle T+1 has done=1, fault=1; no memory access.
  - Else: store -> WR_LO; load -> RD.
- WR_LO (store):
  - mem_MemWrite=1; mem_Din = wdata replicated across lanes.
  - sel for W is 1111; for B it is the one-hot lane of addr[1:0]; for H it is the one-hot lane of {addr[1],0}.
  - Memory commits at the end of the cycle. B/W go to IDLE with done=1 next cycle. H goes to WR_HI.
- WR_HI: mem_MemWrite=1; sel = one-hot lane of {addr[1],1}; mem_Din carries wdata[15:8] in that lane. Then IDLE, done=1.
- RD:
  - mem_MemWrite=0, sel=0. On the edge, capture rdata from mem_Dout.
  - Byte select uses addr[1:0]; half select uses addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W passes through.
  - Then IDLE, done=1.
- Latency from the req edge to done: B/W store 2 cycles, H store 3, load 2, fault 1.
- done/fault are registered and cleared after one cycle. fault=0 whenever done follows a non-fault access.
- Back-to-back: the done cycle is IDLE, so a req there is accepted.
- req while busy=1 is ignored entirely.
- Outside access states: mem_MemWrite=0, mem_sel=0, mem_Din=0; mem_Addr holds its last value.
- Reset during WR_HI: the low byte stays written; there is no rollback and no done.

Optional Feature:
STORE_READBACK_EN
- Defined: each store adds a VERIFY state after its last write.
  - In VERIFY, mem_MemWrite=0 and mem_Addr is unchanged.
  - The written lanes of mem_Dout are compared against the lane-positioned wdata.
  - Mismatch: done=1 with fault=1; match: fault=0.
  - Store latency grows by 1 (B/W 3, H 4).
- Undefined: no VERIFY state; latencies as above.

Test Plan:
1. sw addr=0x8, wdata=0xDEADBEEF -> T+1: mem_Addr=2, sel=1111, MemWrite=1, Din=0xDEADBEEF; T+2: done=1, fault=0. Then lw 0x8 -> rdata=0xDEADBEEF at done.
2. Word1=0x11223344; sh addr=0x6, wdata=0x0000A55A -> T+1: sel=0100, Din[23:16]=0x5A; T+2: sel=1000, Din[31:24]=0xA5; T+3: done. Word1 reads 0xA55A3344.
3. Loads on word1=0xA55A3344 -> lb 0x7 gives 0xFFFFFFA5; lbu 0x7 gives 0x000000A5; lh 0x6 gives 0xFFFFA55A; lhu 0x4 gives 0x00003344; each with done at T+2.
4. sw 0x2, lh 0x3, op=011, sb with op=100 -> done=1, fault=1 at T+1; MemWrite never asserted; rdata unchanged.
5. rst_n low mid-WR_HI of test 2's sh -> MemWrite, busy, done go to 0 asynchronously. Word1 = 0x115A3344.
6. req held high during an sh -> a single transaction only. A new sb req=1 on the done cycle -> accepted; second done 2 cycles later.
